// File: rtl/serial_pattern_generator_fsm_pkg.sv
// Shared types and constants for the serial pattern generator.
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Pattern recognised by the companion "110011" detector.
  localparam logic [5:0] DEFAULT_PATTERN = 6'b110011;

endpackage

// File: rtl/serial_pattern_generator_fsm_if.sv
// Request and serial-stream bundle between a controller and the pattern generator.
interface serial_pattern_generator_fsm_if #(
  parameter int WIDTH = 6,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] pattern;
  logic [REP_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             a;
  logic             a_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, pattern, repeat_n, gap,
    input  a, a_valid, busy, done
  );

  modport slave (
    input  start, stop, pattern, repeat_n, gap,
    output a, a_valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_generator_fsm_shreg.sv
// Parallel-load, shift-left register exposing its MSB as the serial bit.
module pattern_shift_reg #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  output logic             msb
);
  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_val;
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];
endmodule

// File: rtl/serial_pattern_generator_fsm.sv
// Emits a captured pattern MSB-first, repeated N times with an optional idle gap.
module serial_pattern_generator_fsm
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  serial_pattern_generator_fsm_if.slave  bus
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [BW-1:0]    bit_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_cnt, gap_q;
  logic [WIDTH-1:0] pat_q;

  logic             accept, abort, last_bit, last_rep, gap_end;
  logic             load, shift, msb;
  logic [WIDTH-1:0] load_val;

  assign accept   = (state == IDLE) && bus.start && !bus.stop;
  assign abort    = bus.stop && ((state == SEND) || (state == GAP));
  assign last_bit = (state == SEND) && (bit_cnt == '0);
  assign last_rep = (rep_cnt == REP_W'(1));
  assign gap_end  = (state == GAP) && (gap_cnt == '0);

  // Shift register is reloaded at every repetition boundary so back-to-back
  // repetitions need no bubble cycle.
  always_comb begin
    load     = 1'b0;
    shift    = 1'b0;
    load_val = pat_q;
    if (accept) begin
      load     = 1'b1;
      load_val = bus.pattern;
    end else if (!abort) begin
      if (state == SEND) begin
        if (last_bit && !last_rep && (gap_q == '0)) load = 1'b1;
        else                                        shift = 1'b1;
      end
      if (gap_end) load = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = SEND;
      SEND: begin
        if (bus.stop)                           state_nx = IDLE;
        else if (last_bit && last_rep)          state_nx = DONE;
        else if (last_bit && (gap_q != '0))     state_nx = GAP;
      end
      GAP: begin
        if (bus.stop)    state_nx = IDLE;
        else if (gap_end) state_nx = SEND;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      gap_q   <= '0;
      pat_q   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (accept) begin
          pat_q   <= bus.pattern;
          rep_cnt <= (bus.repeat_n == '0) ? REP_W'(1) : bus.repeat_n;
          gap_q   <= bus.gap;
          bit_cnt <= BIT_LAST;
        end
        SEND: if (!bus.stop) begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (!last_rep) begin
            if (gap_q != '0) begin
              gap_cnt <= gap_q - 1'b1;
            end else begin
              bit_cnt <= BIT_LAST;
              rep_cnt <= rep_cnt - 1'b1;
            end
          end
        end
        GAP: if (!bus.stop) begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else begin
            bit_cnt <= BIT_LAST;
            rep_cnt <= rep_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pattern_shift_reg #(.WIDTH(WIDTH)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .shift    (shift),
    .msb      (msb)
  );

  assign bus.a_valid = (state == SEND);
  assign bus.a       = (state == SEND) && msb;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_serial_pattern_generator_fsm.sv
// Table-driven bench with a per-cycle expectation queue and a chained "110011" detector.
module tb_serial_pattern_generator_fsm;
  import serial_pattern_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_pattern_generator_fsm_if #(.WIDTH(6), .REP_W(4), .GAP_W(4)) bus ();

  serial_pattern_generator_fsm #(.WIDTH(6), .REP_W(4), .GAP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [5:0] pattern;
    int         rep;
    int         gap;
    int         stop_at;        // cycle index (from first bit) where stop is held, -1 none
    int         busy_start_at;  // cycle index where a stray start is pulsed, -1 none
    int         det;            // expected "110011" detections
  } vec_t;

  vec_t       vecs [8];
  logic [3:0] exp_q [$];        // {busy, done, a_valid, a} per cycle
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {busy,done,a_valid,a}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic build_expect(input vec_t v);
    logic [3:0] full [$];
    int n;
    n = (v.rep == 0) ? 1 : v.rep;
    for (int r = 0; r < n; r++) begin
      for (int i = 0; i < 6; i++) full.push_back({3'b101, v.pattern[5-i]});
      if (r < n - 1)
        for (int g = 0; g < v.gap; g++) full.push_back(4'b1000);
    end
    exp_q.delete();
    if (v.stop_at >= 0) begin
      for (int i = 0; i <= v.stop_at; i++) exp_q.push_back(full[i]);
    end else begin
      foreach (full[i]) exp_q.push_back(full[i]);
      exp_q.push_back(4'b1100);
    end
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
  endtask

  task automatic run_vector(input int id, input vec_t v);
    logic [3:0] got, exp;
    logic [5:0] hist;
    int cyc, vcnt, det;
    build_expect(v);
    hist = '0; vcnt = 0; det = 0; cyc = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.stop = 1'b0;
    bus.pattern = v.pattern; bus.repeat_n = 4'(v.rep); bus.gap = 4'(v.gap);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.pattern = 6'($urandom); bus.repeat_n = 4'($urandom); bus.gap = 4'($urandom);
    while (exp_q.size() > 0) begin
      bus.stop  = (cyc == v.stop_at);
      bus.start = (cyc == v.busy_start_at);
      @(negedge clk);
      got = {bus.busy, bus.done, bus.a_valid, bus.a};
      exp = exp_q.pop_front();
      check($sformatf("vec%0d_cyc%0d", id, cyc), got, exp);
      if (bus.a_valid) begin
        hist = {hist[4:0], bus.a};
        vcnt++;
        if (vcnt >= 6 && hist == DEFAULT_PATTERN) det++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.stop = 1'b0; bus.start = 1'b0;
    check_int($sformatf("vec%0d_detections", id), det, v.det);
  endtask

  initial begin
    vecs[0] = '{6'b110011, 1,  0, -1, -1, 1};
    vecs[1] = '{6'b110011, 2,  0, -1, -1, 2};
    vecs[2] = '{6'b110011, 2,  3, -1, -1, 2};
    vecs[3] = '{6'b101010, 0,  0, -1, -1, 0};
    vecs[4] = '{6'b110011, 1,  0,  2, -1, 0};
    vecs[5] = '{6'b100101, 3,  1, -1,  8, 0};
    vecs[6] = '{6'b011111, 15, 15, -1, 40, 0};
    vecs[7] = '{6'b111000, 1,  5, -1,  2, 0};

    bus.start = 1'b0; bus.stop = 1'b0;
    bus.pattern = '0; bus.repeat_n = '0; bus.gap = '0;
    #12;
    check("reset_state", {bus.busy, bus.done, bus.a_valid, bus.a}, 4'b0000);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) run_vector(i, vecs[i]);

    // start together with stop in IDLE must not launch
    @(posedge clk); #1;
    bus.start = 1'b1; bus.stop = 1'b1; bus.pattern = 6'b111111; bus.repeat_n = 4'd2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("start_stop_idle_%0d", i), {bus.busy, bus.done, bus.a_valid, bus.a}, 4'b0000);
    end

    // asynchronous reset mid-gap, then a normal burst
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pattern = 6'b110011; bus.repeat_n = 4'd2; bus.gap = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("in_gap", {bus.busy, bus.done, bus.a_valid, bus.a}, 4'b1000);
    #1 rst = 1'b1;
    #1;
    check("async_rst", {bus.busy, bus.done, bus.a_valid, bus.a}, 4'b0000);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("after_rst_idle", {bus.busy, bus.done, bus.a_valid, bus.a}, 4'b0000);
    run_vector(8, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_pattern_generator_fsm.md
Name: serial_pattern_generator_fsm

Overview:
- Serial bit-stream generator: the transmit end for the codebase's serial sequence detectors.
- Captures a WIDTH-bit pattern on start and emits it MSB-first, one bit per clock on `a`, qualified by `a_valid`.
- Repeats the pattern a programmable number of times, with an optional idle gap between repetitions.
- Used as bench stimulus and on-chip test source feeding detector FSMs (e.g. a "110011" detector).

Parameters:
- WIDTH, 6, pattern length in bits (>= 2).
- REP_W, 4, width of the repeat-count input.
- GAP_W, 4, width of the gap-length input.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- stop  input  1  abort; honoured in SEND and GAP.
- pattern  input  WIDTH  bits to send, MSB first; captured on accepted start.
- repeat_n  input  REP_W  number of repetitions; 0 is treated as 1; captured on start.
- gap  input  GAP_W  idle cycles between repetitions; 0 means back-to-back; captured on start.
- a  output  1  serial data bit; 0 whenever a_valid = 0.
- a_valid  output  1  a carries a pattern bit this cycle.
- busy  output  1  high in SEND, GAP and DONE.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset (async, immediate): state = IDLE; a, a_valid, busy, done = 0; shift register and all counters = 0. Reset mid-operation abandons the burst, with no done pulse.
- States: IDLE, SEND, GAP, DONE. All outputs are Moore, decoded from registered state and shift-register MSB.
- IDLE:
  - start = 1 and stop = 0 at an edge: capture pattern, repeat_n (0 -> 1), gap; bit_cnt = WIDTH-1; go to SEND.
  - Otherwise stay in IDLE. stop wins over a simultaneous start.
- SEND:
  - a_valid = 1; a = shreg[WIDTH-1].
  - Each edge: shift left, decrement bit_cnt.
  - At the edge where bit_cnt = 0:
    - Last repetition: go to DONE.
    - Otherwise, gap > 0: go to GAP with gap_cnt = gap-1.
    - Otherwise (gap = 0): reload shreg from the captured pattern, reset bit_cnt, decrement rep_cnt, stay in SEND. Repetitions run back-to-back with no bubble.
- GAP:
  - a = 0, a_valid = 0.
  - At gap_cnt = 0: reload shreg, decrement rep_cnt, go to SEND. The gap lasts exactly `gap` cycles.
- DONE: done = 1 for exactly one cycle, then IDLE.
- stop = 1 in SEND or GAP: next state IDLE; no done pulse. The bit on `a` in that cycle is still valid.
- start is ignored while busy. pattern, repeat_n and gap may change freely after capture.
- Latency:
  - Start accepted at edge k: first bit is valid in the cycle after edge k.
  - Total burst length = N·WIDTH + (N-1)·gap cycles (N = effective repeat count), followed by one DONE cycle.
- Width rules: bit_cnt is $clog2(WIDTH) bits; rep_cnt is REP_W bits; gap_cnt is GAP_W bits. Counters never wrap: each transitions at 0 instead of decrementing.

Decomposition:
- Package serial_pattern_pkg: state enum (logic[1:0]: IDLE, SEND, GAP, DONE) and the default pattern constant 6'b110011.
- One sub-module, pattern_shift_reg: parallel load, shift-left enable, MSB out.
- FSM and counters stay in the top module.

Test Plan:
- pattern = 6'b110011, repeat_n = 1, gap = 0, start pulse -> a_valid high 6 cycles with a = 1,1,0,0,1,1; done pulse in cycle 7; busy high cycles 1-7. A chained "110011" detector fires exactly once.
- Same pattern, repeat_n = 2, gap = 0 -> 12 consecutive valid bits; chained detector fires at bits 6 and 12; done in cycle 13.
- Same pattern, repeat_n = 2, gap = 3 -> 6 valid bits, 3 cycles with a_valid = 0 and a = 0, 6 valid bits, done in cycle 16.
- repeat_n = 0, pattern = 6'b101010 -> behaves as a single repetition; a = 1,0,1,0,1,0; done in cycle 7.
- stop asserted during bit 3 -> a_valid = 0 from the next cycle; no done pulse; busy = 0. A start asserted together with stop while in IDLE does not launch.
- Start asserted while busy is ignored; burst length is unchanged. Async rst asserted mid-GAP -> all outputs 0 immediately, state IDLE, and a new start after reset works normally.
